// File: rtl/mito_pkg.sv
// rtl/mito_pkg.sv - shared MITO layer codes, sequencer states and read-phase codes
package mito_pkg;

    typedef enum logic [1:0] {
        NONE        = 2'd0,
        CONVOLUTION = 2'd1,
        POOLING     = 2'd2,
        FULLY       = 2'd3
    } layer_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_IFM,
        RD_WGT,
        RD_BIAS,
        LOAD,
        COMPUTE,
        NEXT,
        FINISH
    } state_e;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_IFM,
        PH_WGT,
        PH_BIAS
    } phase_e;

    function automatic phase_e state_phase(state_e s);
        case (s)
            RD_IFM:  return PH_IFM;
            RD_WGT:  return PH_WGT;
            RD_BIAS: return PH_BIAS;
            default: return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mito_beat_counter.sv
// rtl/mito_beat_counter.sv - per-phase read beat counter with clear priority over increment
module mito_beat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_counter,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_counter) begin
        if (!rst_counter) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mito_layer_sequencer.sv
// rtl/mito_layer_sequencer.sv - steps each layer through IFM/weight/bias reads, load, compute
module mito_layer_sequencer
    import mito_pkg::*;
#(
    parameter int                    NUM_LAYERS = 3,
    parameter logic [2*NUM_LAYERS-1:0] LAYER_SEQ = {FULLY, POOLING, CONVOLUTION},
    parameter int                    IFM_BEATS  = 3,
    parameter int                    WGT_BEATS  = 3,
    parameter int                    BIAS_BEATS = 1,
    parameter int                    CNT_W      = 8,
    localparam int                   IDX_W      = $clog2(NUM_LAYERS + 1)
) (
    input  logic             clk,
    input  logic             rst_counter,
    input  logic             start,
    input  logic             mem_ready,
    input  logic             ofm_valid,
    output logic [1:0]       layer_type,
    output logic [IDX_W-1:0] layer_idx,
    output logic             ifm_read,
    output logic             wgt_read,
    output logic             bias_read,
    output logic             input_load,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy,
    output logic             done
);

    if (IFM_BEATS < 1 || WGT_BEATS < 1 || BIAS_BEATS < 1 ||
        IFM_BEATS >= 2**CNT_W || WGT_BEATS >= 2**CNT_W || BIAS_BEATS >= 2**CNT_W) begin : g_bad_beats
        $error("mito_layer_sequencer: beat counts must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] IFM_LAST  = CNT_W'(IFM_BEATS - 1);
    localparam logic [CNT_W-1:0] WGT_LAST  = CNT_W'(WGT_BEATS - 1);
    localparam logic [CNT_W-1:0] BIAS_LAST = CNT_W'(BIAS_BEATS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_LAYERS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    phase_e           phase;
    layer_e           cur_layer;
    logic             last_beat;
    logic             accept;

    assign phase     = state_phase(state_q);
    assign cur_layer = layer_e'(LAYER_SEQ[2*int'(idx_q) +: 2]);
    assign accept    = (phase != PH_NONE) && mem_ready;

    always_comb begin
        last_beat = 1'b0;
        case (phase)
            PH_IFM:  last_beat = (beat_cnt == IFM_LAST);
            PH_WGT:  last_beat = (beat_cnt == WGT_LAST);
            PH_BIAS: last_beat = (beat_cnt == BIAS_LAST);
            default: last_beat = 1'b0;
        endcase
    end

    // Pooling layers carry no weights or bias, so their IFM phase goes straight to LOAD.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_IFM;
                    idx_d   = '0;
                end
            end
            RD_IFM:  if (accept && last_beat) state_d = (cur_layer == POOLING) ? LOAD : RD_WGT;
            RD_WGT:  if (accept && last_beat) state_d = RD_BIAS;
            RD_BIAS: if (accept && last_beat) state_d = LOAD;
            LOAD:    state_d = COMPUTE;
            COMPUTE: if (ofm_valid) state_d = NEXT;
            NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RD_IFM;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_counter) begin
        if (!rst_counter) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    mito_beat_counter #(
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk         (clk),
        .rst_counter (rst_counter),
        .clr         (state_d != state_q),
        .inc         (accept),
        .count       (beat_cnt)
    );

    assign layer_idx  = idx_q;
    assign ifm_read   = (state_q == RD_IFM);
    assign wgt_read   = (state_q == RD_WGT);
    assign bias_read  = (state_q == RD_BIAS);
    assign input_load = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH);
    assign layer_type = (busy && !done) ? cur_layer : NONE;

endmodule
